// File: rtl/multicycle_control_unit.sv
// Multi-cycle FETCH/DECODE/EXECUTE/MEMORY/WRITEBACK sequencer for an RV32I-subset datapath.
// Optional `ILLEGAL_TRAP_EN: unsupported opcodes halt and raise Illegal instead of acting as a NOP.
module multicycle_control_unit #(
  parameter int ALU_OP_W     = 2,
  parameter int RETIRE_CNT_W = 32
) (
  input  logic                    Clock,
  input  logic                    Reset,
  input  logic [31:0]             Instruction,
  input  logic                    Mem_Ready,
  input  logic                    Zero,
  output logic                    Mem_Req,
  output logic                    Mem_Write,
  output logic                    Addr_Sel,
  output logic                    IR_Write,
  output logic                    PC_Write,
  output logic                    PC_Src,
  output logic [1:0]              Imm_Select,
  output logic                    ALU_Src,
  output logic [ALU_OP_W-1:0]     ALU_Op,
  output logic                    Reg_Write,
  output logic                    Mem_To_Reg,
  output logic [RETIRE_CNT_W-1:0] Retired_Count
`ifdef ILLEGAL_TRAP_EN
  ,
  output logic                    Illegal
`endif
);

  localparam logic [6:0] OP_R    = 7'b0110011;
  localparam logic [6:0] OP_I    = 7'b0010011;
  localparam logic [6:0] OP_LW   = 7'b0000011;
  localparam logic [6:0] OP_SW   = 7'b0100011;
  localparam logic [6:0] OP_BEQ  = 7'b1100011;

  typedef enum logic [2:0] {
    S_FETCH,
    S_DECODE,
    S_EXECUTE,
    S_MEMORY,
    S_WRITEBACK
`ifdef ILLEGAL_TRAP_EN
    ,
    S_HALT
`endif
  } state_t;

  state_t      state, state_nxt;
  logic [31:0] ir;
  logic [6:0]  opcode;
  logic        retire;
  logic        unused_ir;

  assign opcode    = ir[6:0];
  assign unused_ir = ^ir[31:7];

  always_ff @(posedge Clock) begin
    if (Reset) begin
      state         <= S_FETCH;
      ir            <= '0;
      Retired_Count <= '0;
    end else begin
      state <= state_nxt;
      if (IR_Write) ir <= Instruction;
      if (retire)   Retired_Count <= Retired_Count + 1'b1;
    end
  end

  always_comb begin
    state_nxt  = state;
    retire     = 1'b0;
    Mem_Req    = 1'b0;
    Mem_Write  = 1'b0;
    Addr_Sel   = 1'b0;
    IR_Write   = 1'b0;
    PC_Write   = 1'b0;
    PC_Src     = 1'b0;
    Imm_Select = 2'b00;
    ALU_Src    = 1'b0;
    ALU_Op     = '0;
    Reg_Write  = 1'b0;
    Mem_To_Reg = 1'b0;
`ifdef ILLEGAL_TRAP_EN
    Illegal    = 1'b0;
`endif
    case (state)
      S_FETCH: begin
        Mem_Req = 1'b1;
        if (Mem_Ready) begin
          IR_Write  = 1'b1;
          PC_Write  = 1'b1;
          state_nxt = S_DECODE;
        end
      end
      S_DECODE: begin
        case (opcode)
          OP_R, OP_I, OP_LW, OP_SW, OP_BEQ: state_nxt = S_EXECUTE;
          default: begin
`ifdef ILLEGAL_TRAP_EN
            state_nxt = S_HALT;
`else
            state_nxt = S_FETCH;
            retire    = 1'b1;
`endif
          end
        endcase
      end
      S_EXECUTE: begin
        state_nxt = S_FETCH;
        case (opcode)
          OP_R: begin
            ALU_Op    = ALU_OP_W'(2);
            state_nxt = S_WRITEBACK;
          end
          OP_I: begin
            ALU_Src   = 1'b1;
            ALU_Op    = ALU_OP_W'(2);
            state_nxt = S_WRITEBACK;
          end
          OP_LW: begin
            ALU_Src   = 1'b1;
            state_nxt = S_MEMORY;
          end
          OP_SW: begin
            ALU_Src    = 1'b1;
            Imm_Select = 2'b01;
            state_nxt  = S_MEMORY;
          end
          OP_BEQ: begin
            ALU_Op     = ALU_OP_W'(1);
            Imm_Select = 2'b10;
            PC_Src     = 1'b1;
            PC_Write   = Zero;
            retire     = 1'b1;
          end
          default: ;
        endcase
      end
      S_MEMORY: begin
        // Keep the address operands steady while the access is outstanding.
        Mem_Req    = 1'b1;
        Addr_Sel   = 1'b1;
        ALU_Src    = 1'b1;
        Mem_Write  = (opcode == OP_SW);
        Imm_Select = (opcode == OP_SW) ? 2'b01 : 2'b00;
        if (Mem_Ready) begin
          if (opcode == OP_SW) begin
            retire    = 1'b1;
            state_nxt = S_FETCH;
          end else begin
            state_nxt = S_WRITEBACK;
          end
        end
      end
      S_WRITEBACK: begin
        Reg_Write  = 1'b1;
        Mem_To_Reg = (opcode == OP_LW);
        ALU_Src    = (opcode != OP_R);
        retire     = 1'b1;
        state_nxt  = S_FETCH;
      end
`ifdef ILLEGAL_TRAP_EN
      S_HALT: Illegal = 1'b1;
`endif
      default: state_nxt = S_FETCH;
    endcase
    // Reset is synchronous, so it must also mask the current cycle's strobes.
    if (Reset) begin
      retire     = 1'b0;
      Mem_Req    = 1'b0;
      Mem_Write  = 1'b0;
      Addr_Sel   = 1'b0;
      IR_Write   = 1'b0;
      PC_Write   = 1'b0;
      PC_Src     = 1'b0;
      Imm_Select = 2'b00;
      ALU_Src    = 1'b0;
      ALU_Op     = '0;
      Reg_Write  = 1'b0;
      Mem_To_Reg = 1'b0;
`ifdef ILLEGAL_TRAP_EN
      Illegal    = 1'b0;
`endif
    end
  end

endmodule

// File: tb/tb_multicycle_control_unit.sv
// Directed per-cycle vector bench for multicycle_control_unit; honours `ILLEGAL_TRAP_EN.
module tb_multicycle_control_unit;

  logic        Clock = 1'b0;
  logic        Reset, Mem_Ready, Zero;
  logic [31:0] Instruction;
  logic        Mem_Req, Mem_Write, Addr_Sel, IR_Write, PC_Write, PC_Src;
  logic [1:0]  Imm_Select, ALU_Op;
  logic        ALU_Src, Reg_Write, Mem_To_Reg;
  logic [31:0] Retired_Count;
  logic        ill;

  multicycle_control_unit #(.ALU_OP_W(2), .RETIRE_CNT_W(32)) dut (
    .Clock(Clock), .Reset(Reset), .Instruction(Instruction), .Mem_Ready(Mem_Ready),
    .Zero(Zero), .Mem_Req(Mem_Req), .Mem_Write(Mem_Write), .Addr_Sel(Addr_Sel),
    .IR_Write(IR_Write), .PC_Write(PC_Write), .PC_Src(PC_Src), .Imm_Select(Imm_Select),
    .ALU_Src(ALU_Src), .ALU_Op(ALU_Op), .Reg_Write(Reg_Write), .Mem_To_Reg(Mem_To_Reg),
    .Retired_Count(Retired_Count)
`ifdef ILLEGAL_TRAP_EN
    , .Illegal(ill)
`endif
  );
`ifndef ILLEGAL_TRAP_EN
  assign ill = 1'b0;
`endif

  always #5 Clock = ~Clock;

  // {req, wr, asel, irw, pcw, pcsrc, imm[1:0], asrc, op[1:0], rw, m2r}
  logic [12:0] outs;
  assign outs = {Mem_Req, Mem_Write, Addr_Sel, IR_Write, PC_Write, PC_Src,
                 Imm_Select, ALU_Src, ALU_Op, Reg_Write, Mem_To_Reg};

  localparam logic [12:0] O_NONE   = 13'b0_0_0_0_0_0_00_0_00_0_0;
  localparam logic [12:0] O_FWAIT  = 13'b1_0_0_0_0_0_00_0_00_0_0;
  localparam logic [12:0] O_FRDY   = 13'b1_0_0_1_1_0_00_0_00_0_0;
  localparam logic [12:0] O_EX_R   = 13'b0_0_0_0_0_0_00_0_10_0_0;
  localparam logic [12:0] O_WB_R   = 13'b0_0_0_0_0_0_00_0_00_1_0;
  localparam logic [12:0] O_EX_I   = 13'b0_0_0_0_0_0_00_1_10_0_0;
  localparam logic [12:0] O_WB_I   = 13'b0_0_0_0_0_0_00_1_00_1_0;
  localparam logic [12:0] O_EX_LW  = 13'b0_0_0_0_0_0_00_1_00_0_0;
  localparam logic [12:0] O_MEM_LW = 13'b1_0_1_0_0_0_00_1_00_0_0;
  localparam logic [12:0] O_WB_LW  = 13'b0_0_0_0_0_0_00_1_00_1_1;
  localparam logic [12:0] O_EX_SW  = 13'b0_0_0_0_0_0_01_1_00_0_0;
  localparam logic [12:0] O_MEM_SW = 13'b1_1_1_0_0_0_01_1_00_0_0;
  localparam logic [12:0] O_BEQ_T  = 13'b0_0_0_0_1_1_10_0_01_0_0;
  localparam logic [12:0] O_BEQ_N  = 13'b0_0_0_0_0_1_10_0_01_0_0;

  localparam logic [31:0] I_ADD  = 32'h002081B3;
  localparam logic [31:0] I_LW   = 32'h00802283;
  localparam logic [31:0] I_SW   = 32'h00502623;
  localparam logic [31:0] I_BEQ  = 32'h00000463;
  localparam logic [31:0] I_ADDI = 32'h00500093;
  localparam logic [31:0] I_BAD  = 32'h0000007F;

  typedef struct {
    logic        rst;
    logic [31:0] instr;
    logic        rdy;
    logic        zero;
    logic [12:0] exp;
    logic [31:0] cnt;
    string       name;
  } vec_t;

  vec_t tv[$];
  int   n_vec = 0;
  int   n_bad = 0;

  task automatic add(input logic rst, input logic [31:0] instr, input logic rdy,
                     input logic zero, input logic [12:0] exp, input logic [31:0] cnt,
                     input string name);
    vec_t v;
    v.rst = rst; v.instr = instr; v.rdy = rdy; v.zero = zero;
    v.exp = exp; v.cnt = cnt; v.name = name;
    tv.push_back(v);
  endtask

  // Drive one cycle, compare at the falling edge, then advance past the rising edge.
  task automatic cycle(input logic rst, input logic [31:0] instr, input logic rdy,
                       input logic zero, input logic [12:0] exp, input logic [31:0] cnt,
                       input logic exp_ill, input string name);
    Reset = rst; Instruction = instr; Mem_Ready = rdy; Zero = zero;
    @(negedge Clock);
    n_vec++;
    if (outs !== exp || Retired_Count !== cnt || ill !== exp_ill) begin
      n_bad++;
      $display("FAIL %s @%0t: outs=%b cnt=%0d ill=%b, expected outs=%b cnt=%0d ill=%b",
               name, $time, outs, Retired_Count, ill, exp, cnt, exp_ill);
    end
    @(posedge Clock);
    #1;
  endtask

  initial begin
    // reset (the first cycle runs before the count has a defined value)
    add(1, I_ADD, 1, 0, O_NONE,   0, "rst1");
    add(1, I_ADD, 1, 0, O_NONE,   0, "rst2");
    // add x3,x1,x2
    add(0, I_ADD, 1, 0, O_FRDY,   0, "add_fetch");
    add(0, I_ADD, 1, 0, O_NONE,   0, "add_decode");
    add(0, I_ADD, 1, 0, O_EX_R,   0, "add_exec");
    add(0, I_ADD, 1, 0, O_WB_R,   0, "add_wb");
    // lw x5,8(x0) with two stall cycles in MEMORY
    add(0, I_LW,  1, 0, O_FRDY,   1, "lw_fetch");
    add(0, I_LW,  1, 0, O_NONE,   1, "lw_decode");
    add(0, I_LW,  1, 0, O_EX_LW,  1, "lw_exec");
    add(0, I_LW,  0, 0, O_MEM_LW, 1, "lw_mem_wait1");
    add(0, I_LW,  0, 0, O_MEM_LW, 1, "lw_mem_wait2");
    add(0, I_LW,  1, 0, O_MEM_LW, 1, "lw_mem_done");
    add(0, I_LW,  1, 0, O_WB_LW,  1, "lw_wb");
    // sw x5,12(x0) with one fetch stall
    add(0, I_SW,  0, 0, O_FWAIT,  2, "sw_fetch_wait");
    add(0, I_SW,  1, 0, O_FRDY,   2, "sw_fetch");
    add(0, I_SW,  1, 0, O_NONE,   2, "sw_decode");
    add(0, I_SW,  1, 0, O_EX_SW,  2, "sw_exec");
    add(0, I_SW,  1, 0, O_MEM_SW, 2, "sw_mem");
    // beq taken then not taken
    add(0, I_BEQ, 1, 0, O_FRDY,   3, "beq_t_fetch");
    add(0, I_BEQ, 1, 0, O_NONE,   3, "beq_t_decode");
    add(0, I_BEQ, 1, 1, O_BEQ_T,  3, "beq_t_exec");
    add(0, I_BEQ, 1, 0, O_FRDY,   4, "beq_n_fetch");
    add(0, I_BEQ, 1, 1, O_NONE,   4, "beq_n_decode");
    add(0, I_BEQ, 1, 0, O_BEQ_N,  4, "beq_n_exec");
    // sw aborted by reset while waiting in MEMORY
    add(0, I_SW,  1, 0, O_FRDY,   5, "swab_fetch");
    add(0, I_SW,  1, 0, O_NONE,   5, "swab_decode");
    add(0, I_SW,  1, 0, O_EX_SW,  5, "swab_exec");
    add(0, I_SW,  0, 0, O_MEM_SW, 5, "swab_mem_wait");
    add(1, I_SW,  1, 0, O_NONE,   5, "swab_reset");
    // restart at FETCH, then an I-ALU op
    add(0, I_ADD, 1, 0, O_FRDY,   0, "restart_fetch");
    add(0, I_ADD, 1, 0, O_NONE,   0, "restart_decode");
    add(0, I_ADD, 1, 0, O_EX_R,   0, "restart_exec");
    add(0, I_ADD, 1, 0, O_WB_R,   0, "restart_wb");
    add(0, I_ADDI,1, 0, O_FRDY,   1, "addi_fetch");
    add(0, I_ADDI,1, 0, O_NONE,   1, "addi_decode");
    add(0, I_ADDI,1, 0, O_EX_I,   1, "addi_exec");
    add(0, I_ADDI,1, 0, O_WB_I,   1, "addi_wb");
    // unsupported opcode
    add(0, I_BAD, 1, 0, O_FRDY,   2, "bad_fetch");
    add(0, I_BAD, 1, 0, O_NONE,   2, "bad_decode");

    // unchecked first reset cycle
    Reset = 1; Instruction = I_ADD; Mem_Ready = 1; Zero = 0;
    @(posedge Clock);
    #1;

    for (int i = 0; i < tv.size(); i++)
      cycle(tv[i].rst, tv[i].instr, tv[i].rdy, tv[i].zero, tv[i].exp, tv[i].cnt, 1'b0, tv[i].name);

`ifdef ILLEGAL_TRAP_EN
    for (int i = 0; i < 10; i++)
      cycle(0, I_ADD, 1, 1, O_NONE, 2, 1'b1, "halt_hold");
    cycle(1, I_ADD, 1, 0, O_NONE, 2, 1'b0, "halt_reset");
    cycle(0, I_ADD, 1, 0, O_FRDY, 0, 1'b0, "halt_restart_fetch");
`else
    cycle(0, I_ADD, 1, 0, O_FRDY, 3, 1'b0, "nop_refetch");
    cycle(0, I_ADD, 1, 0, O_NONE, 3, 1'b0, "nop_next_decode");
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/multicycle_control_unit.md
Name: multicycle_control_unit

Overview:
- Multi-cycle sequencer for the RV32I-subset datapath: register file, ALU, memory port, PC and the 12-bit to 32-bit immediate generator.
- Latches the fetched instruction and steps an FSM through FETCH/DECODE/EXECUTE/MEMORY/WRITEBACK.
- Drives all datapath enables, the immediate-format select and the ALU op class.
- Handshakes with a shared instruction/data memory port; counts retired instructions.

Parameters:
- ALU_OP_W, 2, width of ALU operation-class output.
- RETIRE_CNT_W, 32, width of retired-instruction counter.

Ports:
- Clock  input  1  single design clock, rising edge.
- Reset  input  1  synchronous, active-high.
- Instruction  input  32  memory read data, valid when Mem_Ready=1 in FETCH.
- Mem_Ready  input  1  memory completion strobe for the current Mem_Req.
- Zero  input  1  ALU zero flag, sampled in EXECUTE.
- Mem_Req  output  1  memory access request, held until Mem_Ready.
- Mem_Write  output  1  1=store, 0=read; qualified by Mem_Req.
- Addr_Sel  output  1  0=PC address (fetch), 1=ALU result (data).
- IR_Write  output  1  instruction register load strobe.
- PC_Write  output  1  PC update strobe.
- PC_Src  output  1  0=PC+4, 1=branch target.
- Imm_Select  output  2  00=I, 01=S, 10=B, 11=reserved.
- ALU_Src  output  1  0=register rs2, 1=immediate.
- ALU_Op  output  ALU_OP_W  00=add, 01=sub (branch compare), 10=funct-decoded.
- Reg_Write  output  1  register file write enable.
- Mem_To_Reg  output  1  writeback source: 0=ALU, 1=memory data.
- Retired_Count  output  RETIRE_CNT_W  count of completed instructions.

Behaviour:
- Reset:
  - State goes to FETCH; IR = 0; Retired_Count = 0.
  - While Reset=1, all strobes and data outputs are 0 (Mem_Req, Mem_Write, Addr_Sel, IR_Write, PC_Write, PC_Src, ALU_Src, Reg_Write, Mem_To_Reg, Imm_Select, ALU_Op).
  - Reset mid-instruction aborts it: no write is issued and the count is not incremented.
- Outputs are Moore-decoded from the state register and the latched IR. The exceptions are IR_Write and fetch PC_Write (gated by Mem_Ready) and the branch PC_Write (gated by Zero).
- FETCH:
  - Mem_Req=1, Addr_Sel=0, Mem_Write=0.
  - Stays in FETCH while Mem_Ready=0; Mem_Req stays high continuously.
  - On Mem_Ready=1: IR_Write=1, PC_Write=1, PC_Src=0, IR loads Instruction, next state DECODE.
- DECODE: one cycle; no strobes. Next state by IR[6:0]:
  - 0110011 R-type -> EXECUTE.
  - 0010011 I-ALU -> EXECUTE.
  - 0000011 lw -> EXECUTE.
  - 0100011 sw -> EXECUTE.
  - 1100011 beq -> EXECUTE.
  - Any other opcode -> see Optional Feature.
- EXECUTE: one cycle.
  - R-type: ALU_Src=0, ALU_Op=10 -> WRITEBACK.
  - I-ALU: ALU_Src=1, Imm_Select=00, ALU_Op=10 -> WRITEBACK.
  - lw: ALU_Src=1, Imm_Select=00, ALU_Op=00 -> MEMORY.
  - sw: ALU_Src=1, Imm_Select=01, ALU_Op=00 -> MEMORY.
  - beq: ALU_Src=0, ALU_Op=01, Imm_Select=10, PC_Src=1, PC_Write=Zero; retire -> FETCH.
- MEMORY:
  - Mem_Req=1, Addr_Sel=1, Mem_Write=1 for sw, 0 for lw; waits on Mem_Ready.
  - On Mem_Ready=1: lw -> WRITEBACK; sw retires -> FETCH.
- WRITEBACK: one cycle; Reg_Write=1, Mem_To_Reg=1 for lw, else 0; retire -> FETCH.
- Imm_Select and ALU_Src hold their EXECUTE values through MEMORY and WRITEBACK, so the address and result stay stable.
- Retire: Retired_Count += 1 on the retiring edge; wraps from all-ones to 0 with no flag.
- Minimum latency with Mem_Ready already high: beq 3, R/I/sw 4, lw 5 cycles.
- Mem_Ready while Mem_Req=0 is ignored.

Optional Feature:
- Macro: ILLEGAL_TRAP_EN.
- Defined:
  - Adds output Illegal (1 bit, reset 0) and state HALT.
  - Unsupported opcode in DECODE -> HALT: Illegal=1, all strobes 0, no retire.
  - Leaves HALT only on Reset.
- Undefined:
  - Unsupported opcode is a NOP: DECODE -> FETCH, counts as retired.
  - No Illegal port, no HALT state.

Test Plan:
- Reset held 3 cycles then released, Mem_Ready=1 -> all outputs 0 during reset; Mem_Req=1, Addr_Sel=0 on the first post-reset cycle.
- add x3,x1,x2 (0x002081B3), Mem_Ready=1 -> FETCH, DECODE, EXECUTE (ALU_Op=10, ALU_Src=0), WRITEBACK (Reg_Write=1, Mem_To_Reg=0); Retired_Count 0->1 in 4 cycles.
- lw x5,8(x0) (0x00802283) with Mem_Ready low 2 cycles in MEMORY -> Mem_Req held, Addr_Sel=1, Mem_Write=0 throughout; then WRITEBACK with Mem_To_Reg=1; total 7 cycles.
- sw x5,12(x0) (0x00502623) -> EXECUTE Imm_Select=01; MEMORY Mem_Write=1; no Reg_Write; 4 cycles.
- beq (0x00000463), Zero=1 then repeated with Zero=0 -> EXECUTE Imm_Select=10, PC_Src=1, PC_Write=1 / 0 respectively; 3 cycles each.
- Opcode 0x0000007F:
  - With ILLEGAL_TRAP_EN: Illegal=1, state stays HALT 10 cycles, count unchanged; Reset clears it.
  - Without: returns to FETCH, count +1.
- Reset asserted in MEMORY of a sw -> Mem_Req and Mem_Write drop that cycle; count unchanged; restarts at FETCH.
